// File: rtl/shrimp_alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, bit-serial shift-add multiply and
// bit-serial shifts, with a valid/ready request and response handshake.
module shrimp_alu_mc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OpXor  = 4'd0;
    localparam logic [3:0] OpAnd  = 4'd1;
    localparam logic [3:0] OpOr   = 4'd2;
    localparam logic [3:0] OpAdd  = 4'd3;
    localparam logic [3:0] OpSub  = 4'd4;
    localparam logic [3:0] OpNeg  = 4'd5;
    localparam logic [3:0] OpCmpu = 4'd6;
    localparam logic [3:0] OpCmps = 4'd7;
    localparam logic [3:0] OpMul  = 4'd8;
    localparam logic [3:0] OpShl  = 4'd9;
    localparam logic [3:0] OpShr  = 4'd10;
    localparam logic [3:0] OpSra  = 4'd11;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    // lo holds the primary result / shift value / multiplier; hi the upper product half
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    logic             live_q;

    logic [WIDTH:0]   sum, diff, mul_add, mul_sum;
    logic [WIDTH-1:0] neg_val;
    logic [SHW-1:0]   amt;

    assign sum     = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff    = {1'b0, operand_a} - {1'b0, operand_b};
    assign neg_val = '0 - operand_a;
    assign amt     = operand_b[SHW-1:0];
    assign mul_add = lo_q[0] ? {1'b0, a_q} : '0;
    assign mul_sum = {1'b0, hi_q} + mul_add;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    op_d    = op_code;
                    a_d     = operand_a;
                    lo_d    = '0;
                    hi_d    = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                    state_d = StDone;
                    case (op_code)
                        OpXor: lo_d = operand_a ^ operand_b;
                        OpAnd: lo_d = operand_a & operand_b;
                        OpOr:  lo_d = operand_a | operand_b;
                        OpAdd: begin
                            lo_d    = sum[WIDTH-1:0];
                            carry_d = sum[WIDTH];
                            ovf_d   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                                      (sum[WIDTH-1] != operand_a[WIDTH-1]);
                        end
                        OpSub: begin
                            lo_d    = diff[WIDTH-1:0];
                            carry_d = diff[WIDTH];
                            ovf_d   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                                      (diff[WIDTH-1] != operand_a[WIDTH-1]);
                        end
                        OpNeg: begin
                            lo_d    = neg_val;
                            carry_d = (operand_a != '0);
                            ovf_d   = (operand_a == {1'b1, {(WIDTH-1){1'b0}}});
                        end
                        OpCmpu: lo_d[2:0] = {operand_a == operand_b, operand_a < operand_b,
                                             operand_a > operand_b};
                        OpCmps: lo_d[2:0] = {operand_a == operand_b,
                                             $signed(operand_a) < $signed(operand_b),
                                             $signed(operand_a) > $signed(operand_b)};
                        OpMul: begin
                            lo_d    = operand_b;
                            cnt_d   = CW'(WIDTH);
                            state_d = StBusy;
                        end
                        OpShl, OpShr, OpSra: begin
                            lo_d  = operand_a;
                            cnt_d = CW'(amt);
                            if (amt != '0) state_d = StBusy;
                        end
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = StDone;
                case (op_q)
                    OpMul: begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                        if (cnt_q == CW'(1)) carry_d = (mul_sum[WIDTH:1] != '0);
                    end
                    OpShl: begin
                        carry_d = lo_q[WIDTH-1];
                        lo_d    = {lo_q[WIDTH-2:0], 1'b0};
                    end
                    OpShr: begin
                        carry_d = lo_q[0];
                        lo_d    = {1'b0, lo_q[WIDTH-1:1]};
                    end
                    default: begin
                        carry_d = lo_q[0];
                        lo_d    = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
                    end
                endcase
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
            live_q  <= 1'b1;
        end
    end

    // live_q keeps in_ready low until the first edge after reset release
    assign in_ready  = live_q && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = out_valid ? lo_q : '0;
    assign result_hi = out_valid ? hi_q : '0;
    assign carry     = out_valid && carry_q;
    assign overflow  = out_valid && ovf_q;
    assign illegal   = out_valid && ill_q;
    assign zero      = out_valid && (lo_q == '0);
    assign negative  = out_valid && lo_q[WIDTH-1];

endmodule

// File: tb/tb_shrimp_alu_mc.sv
// Randomized and directed bench for shrimp_alu_mc (WIDTH=8) against an arithmetic reference model.
module tb_shrimp_alu_mc;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op_code;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;
    logic       illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [20:0] obs;
    assign obs = {result_hi, result, carry, overflow, zero, negative, illegal};

    shrimp_alu_mc #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response packed as {result_hi, result, carry, overflow, zero, negative, illegal}
    function automatic logic [20:0] model_resp(input logic [3:0] op, input logic [7:0] a,
                                               input logic [7:0] b);
        int ua, ub, sa, sb, amt, r, h, c, v, il, t;
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua >= 128) ? ua - 256 : ua;
        sb  = (ub >= 128) ? ub - 256 : ub;
        amt = ub % 8;
        r = 0; h = 0; c = 0; v = 0; il = 0;
        case (op)
            4'd0: r = ua ^ ub;
            4'd1: r = ua & ub;
            4'd2: r = ua | ub;
            4'd3: begin
                t = ua + ub;
                r = t % 256;
                c = (t >= 256) ? 1 : 0;
                v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0;
            end
            4'd4: begin
                t = ua - ub;
                r = (t + 256) % 256;
                c = (ua < ub) ? 1 : 0;
                v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
            end
            4'd5: begin
                r = (256 - ua) % 256;
                c = (ua != 0) ? 1 : 0;
                v = (ua == 128) ? 1 : 0;
            end
            4'd6: r = (ua > ub ? 1 : 0) + (ua < ub ? 2 : 0) + (ua == ub ? 4 : 0);
            4'd7: r = (sa > sb ? 1 : 0) + (sa < sb ? 2 : 0) + (sa == sb ? 4 : 0);
            4'd8: begin
                t = ua * ub;
                r = t % 256;
                h = t / 256;
                c = (h != 0) ? 1 : 0;
            end
            4'd9: begin
                r = (ua << amt) % 256;
                c = (amt == 0) ? 0 : (ua >> (8 - amt)) & 1;
            end
            4'd10: begin
                r = ua >> amt;
                c = (amt == 0) ? 0 : (ua >> (amt - 1)) & 1;
            end
            4'd11: begin
                r = (sa >>> amt) & 255;
                c = (amt == 0) ? 0 : (sa >>> (amt - 1)) & 1;
            end
            default: il = 1;
        endcase
        return {8'(h), 8'(r), 1'(c), 1'(v), r == 0, r >= 128, 1'(il)};
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [7:0] b);
        if (op == 4'd8) return 9;
        if (op >= 4'd9 && op <= 4'd11) return int'(b % 8) + 1;
        return 1;
    endfunction

    // Issue one request, scramble inputs while in flight, then hold off out_ready for `hold` cycles
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold);
        logic [20:0] exp;
        int          exp_lat;
        int          lat;
        exp     = model_resp(op, a, b);
        exp_lat = model_lat(op, b);
        @(negedge clk);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op_code   = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        op_code   = 4'($urandom);
        operand_a = 8'($urandom);
        operand_b = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("resp", 32'(obs), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_resp", 32'(obs), 32'(exp));
            check_eq("hold_vld_rdy", 32'({out_valid, in_ready}), 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("release_vld_rdy", 32'({out_valid, in_ready}), 32'd1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_code   = '0;
        operand_a = '0;
        operand_b = '0;

        #23;
        check_eq("reset_outputs", 32'({in_ready, out_valid, obs}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("ready_after_edge", 32'(in_ready), 32'd1);

        run_op(4'd3, 8'hFF, 8'h01, 0);
        run_op(4'd3, 8'h7F, 8'h01, 1);
        run_op(4'd4, 8'h00, 8'h01, 0);
        run_op(4'd8, 8'hFF, 8'hFF, 0);
        run_op(4'd11, 8'h90, 8'h03, 5);
        run_op(4'd7, 8'h80, 8'h01, 0);
        run_op(4'd6, 8'h80, 8'h01, 0);
        run_op(4'd13, 8'h5A, 8'hA5, 0);
        run_op(4'd5, 8'h80, 8'h00, 0);
        run_op(4'd9, 8'hC3, 8'h08, 0);
        run_op(4'd10, 8'h81, 8'h07, 2);

        // Abort a multiply in its fourth BUSY cycle
        @(negedge clk);
        in_valid  = 1'b1;
        op_code   = 4'd8;
        operand_a = 8'hFF;
        operand_b = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_outputs", 32'({in_ready, out_valid, obs}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_ready", 32'({out_valid, in_ready}), 32'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("abort_no_resp", 32'(seen), 32'd0);

        for (int n = 0; n < 80; n++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
